// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared types and constants for the instruction-memory loader.
//   - loader_state_t : frame parser states
//   - SYNC_BYTE_DEF  : default frame start marker
//   - WORD_W         : instruction word width
//   - frame_idle_like: states that hunt for a SYNC byte
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int         WORD_W        = 32;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } loader_state_t;

  // IDLE, DONE and ERROR all wait for a SYNC byte; they differ only in the
  // status flags they leave behind.
  function automatic logic frame_idle_like(input loader_state_t st);
    return (st == IDLE) || (st == DONE) || (st == ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Byte stream in (valid/ready) and instruction-memory write port out.
//   - s_data/s_valid/s_ready : byte stream handshake
//   - imem_we/addr/wdata     : one-cycle word write strobe
//   Modports: slave = loader side, master = stream source / memory side.
// ---------------------------------------------------------------------------
interface imem_loader_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) ();

  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport slave (
    input  s_data, s_valid,
    output s_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output s_data, s_valid,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
//   4-byte MSB-first shift register with a byte counter.
//   - clk, rst  : clock, async active-high reset
//   - clr       : restart at byte 0 of a word (word contents kept)
//   - load, din : shift din into the low byte
//   - word      : packed word (first byte ends up in [31:24])
//   - word_full : this load completes a word
// ---------------------------------------------------------------------------
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [1:0] cnt;

  // Flagged combinationally so the parent can step to WRITE on the same
  // edge that the fourth byte lands in the register.
  assign word_full = load && !clr && (cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      cnt  <= 2'd0;
    end else if (clr) begin
      cnt  <= 2'd0;
    end else if (load) begin
      word <= {word[WORD_W-9:0], din};
      cnt  <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Parses SYNC, LEN_HI, LEN_LO, 4*N data bytes, CSUM from a byte stream,
//   writes big-endian words to instruction memory from address 0 and holds
//   the fetch stage until the XOR checksum of the data bytes matches.
//   - clk, rst      : clock, async active-high reset
//   - bus (slave)   : byte stream in, imem write port out
//   - cpu_hold      : fetch stall, released only after a good frame
//   - load_done     : a verified program is resident
//   - load_error    : last frame rejected (bad length or checksum)
//   - words_loaded  : words written in the current/last frame
// ---------------------------------------------------------------------------
module imem_loader
  import mips_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_error,
  output logic [ADDR_W:0] words_loaded
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  loader_state_t     state, state_n;
  logic              s_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_hi_q;
  logic [7:0]        csum_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   word_idx_q;

  logic              accept;
  logic [16:0]       len_n;
  logic              len_bad;
  logic              pk_clr;
  logic              pk_load;
  logic              pk_full;
  logic [WORD_W-1:0] pk_word;

  assign accept  = bus.s_valid && s_ready_q;
  assign len_n   = {1'b0, len_hi_q, bus.s_data};
  // Rejecting oversize lengths here is what keeps word_idx from wrapping.
  assign len_bad = (len_n == 17'd0) || (len_n > DEPTH);
  assign pk_load = (state == DATA) && accept;
  assign pk_clr  = (state == LEN_LO) && accept;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pk_clr),
    .load      (pk_load),
    .din       (bus.s_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  assign bus.s_ready    = s_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  // The packer register holds the finished word throughout WRITE because
  // s_ready is low there, so it can drive the write data directly.
  assign bus.imem_wdata = pk_word;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERROR: if (accept && bus.s_data == SYNC_BYTE) state_n = LEN_HI;
      LEN_HI:            if (accept) state_n = LEN_LO;
      LEN_LO:            if (accept) state_n = len_bad ? ERROR : DATA;
      DATA:              if (pk_full) state_n = WRITE;
      // word_idx_q has already been bumped for the word being written.
      WRITE:             state_n = (word_idx_q == len_q) ? CSUM : DATA;
      CSUM:              if (accept) state_n = (bus.s_data == csum_q) ? DONE : ERROR;
      default:           state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      s_ready_q    <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      len_hi_q     <= 8'd0;
      csum_q       <= 8'd0;
      len_q        <= '0;
      word_idx_q   <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      state     <= state_n;
      // Registered from the next state so the stall lines up with WRITE.
      s_ready_q <= (state_n != WRITE);
      we_q      <= (state_n == WRITE);

      if (frame_idle_like(state) && state_n == LEN_HI) begin
        cpu_hold     <= 1'b1;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
        words_loaded <= '0;
      end

      if (state == LEN_HI && accept) len_hi_q <= bus.s_data;

      if (pk_clr) begin
        len_q      <= len_n[ADDR_W:0];
        word_idx_q <= '0;
        csum_q     <= 8'd0;
      end

      if (pk_load) begin
        csum_q <= csum_q ^ bus.s_data;
        if (pk_full) begin
          addr_q       <= word_idx_q[ADDR_W-1:0];
          word_idx_q   <= word_idx_q + 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
      end

      if (state == CSUM && state_n == DONE) begin
        load_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end

      // Already-written words stay in memory; only the flags change.
      if (state_n == ERROR && state != ERROR) begin
        load_error <= 1'b1;
        load_done  <= 1'b0;
        cpu_hold   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Receives a framed byte stream (from a host UART or debug bridge) over a valid/ready interface and packs bytes into big-endian 32-bit words.
- Writes each word to consecutive word addresses of instruction memory starting at 0.
- Holds the fetch stage until a complete, checksum-verified program has been loaded.

Parameters:
- ADDR_W, 8: instruction memory word-address width; depth = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_data  input  8  stream byte.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write enable, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_hold  output  1  stalls/holds the fetch stage while high.
- load_done  output  1  a valid program is resident.
- load_error  output  1  the last frame was rejected.
- words_loaded  output  ADDR_W+1  count of words written in the current or last frame.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst). All outputs are registered.
- Reset values:
  - state=IDLE, s_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, load_done=0, load_error=0, words_loaded=0.
- Handshake: a byte is taken only when s_valid && s_ready. s_data is ignored otherwise. s_valid may stay high across s_ready=0 cycles.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then 4*N data bytes, then CSUM.
  - N = {LEN_HI, LEN_LO}.
  - Data is MSB first within each word.
  - CSUM = XOR of all 4*N data bytes.
- FSM:
  - IDLE: accepted byte == SYNC_BYTE -> LEN_HI, and cpu_hold=1, load_done=0, load_error=0, words_loaded=0. Any other byte is discarded.
  - LEN_HI: store the high byte -> LEN_LO.
  - LEN_LO: form N. If N==0 or N > 2**ADDR_W -> ERROR. Else -> DATA, with byte index=0, word index=0, checksum=0.
  - DATA: shift the byte into the 32-bit packer and XOR it into the checksum. On the 4th byte of a word -> WRITE.
  - WRITE (exactly one cycle):
    - imem_we=1, imem_addr=word index, imem_wdata=packed word; s_ready=0.
    - words_loaded increments.
    - Next state is DATA if words remain, else CSUM.
  - CSUM: accepted byte == checksum -> DONE; mismatch -> ERROR.
  - DONE: load_done=1, cpu_hold=0. Behaves as IDLE, so a SYNC_BYTE starts a new load and reasserts cpu_hold the next cycle.
  - ERROR: load_error=1, cpu_hold=1, load_done=0. Behaves as IDLE for SYNC_BYTE.
- Latency:
  - The 4th byte of a word accepted in cycle t gives imem_we=1 in cycle t+1.
  - The CSUM byte accepted in cycle t gives load_done=1 and cpu_hold=0 in cycle t+1.
- imem_we is never asserted outside WRITE. Words already written before an ERROR are not rolled back.
- A SYNC_BYTE value appearing inside LEN, DATA or CSUM is treated as ordinary data. There is no resynchronisation mid-frame.
- Reset asserted mid-frame: immediate return to IDLE with reset values. Memory contents are untouched.
- The word index never wraps, because N is checked against depth before DATA.

Decomposition:
- Shared package mips_pkg holds:
  - loader_state_t (IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERROR);
  - SYNC_BYTE default;
  - the word width constant 32.
- One sub-module, byte_packer: 4-byte MSB-first shift register with a byte counter. Inputs are load strobe and clear; outputs are word and word_full.

Test Plan:
- Reset then frame A5 00 01 12 34 56 78 CSUM=0x08 -> imem_we one cycle with addr=0, wdata=0x12345678; next cycle after CSUM load_done=1, cpu_hold=0, words_loaded=1.
- Frame of N=3 with s_valid held high continuously -> writes at addr 0,1,2; s_ready=0 exactly in each WRITE cycle; no byte lost or duplicated.
- Frame N=1 data 11 22 33 44 CSUM=0x00 (correct value 0x44) -> word still written at addr 0; load_error=1, load_done=0, cpu_hold=1.
- LEN = 0x0000 and LEN = 0x0101 (with ADDR_W=8) -> ERROR directly after LEN_LO; imem_we never asserted.
- Garbage bytes 00 FF 5A before A5 in IDLE -> ignored; the following frame loads normally.
- rst pulsed after 2 data bytes of a word -> all outputs at reset values asynchronously; a subsequent full frame loads correctly from addr 0.
